// File: rtl/decoder_scanner.sv
// One-hot decoder with direct and scan commands; optional scan mode under DECODER_SCAN_EN.
// All outputs are registered; enable=0 blanks y and freezes the sequencer.
module decoder_scanner #(
    parameter int N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic             mode,
    input  logic [N-1:0]     addr,
    output logic [2**N-1:0]  y,
    output logic             busy,
    output logic             scan_done
);
    localparam int W = 2**N;
    localparam logic [W-1:0] ONE = W'(1);

    // state  | meaning
    // IDLE   | waiting for load, y=0
    // DIRECT | showing 1<<idx for one enabled cycle
    // SCAN   | stepping idx through all 2**N positions
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1
`ifdef DECODER_SCAN_EN
        ,SCAN  = 2'd2
`endif
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   idx, idx_nxt;
    logic           held, held_nxt;
    logic [W-1:0]   y_nxt;
    logic           busy_nxt;

`ifdef DECODER_SCAN_EN
    localparam logic [N-1:0] LAST = {N{1'b1}};
    logic [N-1:0]   step, step_nxt;
    logic           done_nxt;
`else
    logic           unused_mode;
    assign unused_mode = mode;
`endif

    // held marks a pause: the first enabled edge afterwards re-displays idx without advancing
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        held_nxt  = held;
        y_nxt     = y;
`ifdef DECODER_SCAN_EN
        step_nxt  = step;
        done_nxt  = 1'b0;
`endif
        if (!enable) begin
            y_nxt    = '0;
            held_nxt = (state != IDLE);
        end else begin
            held_nxt = 1'b0;
            case (state)
                IDLE: begin
                    y_nxt = '0;
                    if (load) begin
                        idx_nxt = addr;
                        y_nxt   = ONE << addr;
`ifdef DECODER_SCAN_EN
                        step_nxt  = '0;
                        state_nxt = mode ? SCAN : DIRECT;
`else
                        state_nxt = DIRECT;
`endif
                    end
                end
                DIRECT: begin
                    if (held) begin
                        y_nxt = ONE << idx;
                    end else begin
                        state_nxt = IDLE;
                        y_nxt     = '0;
                    end
                end
`ifdef DECODER_SCAN_EN
                SCAN: begin
                    if (held) begin
                        y_nxt    = ONE << idx;
                        done_nxt = (step == LAST);
                    end else if (step == LAST) begin
                        state_nxt = IDLE;
                        y_nxt     = '0;
                    end else begin
                        idx_nxt  = idx + N'(1);
                        step_nxt = step + N'(1);
                        y_nxt    = ONE << idx_nxt;
                        done_nxt = (step_nxt == LAST);
                    end
                end
`endif
                default: begin
                    state_nxt = IDLE;
                    y_nxt     = '0;
                end
            endcase
        end
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            held  <= 1'b0;
            y     <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            held  <= held_nxt;
            y     <= y_nxt;
            busy  <= busy_nxt;
        end
    end

`ifdef DECODER_SCAN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step      <= '0;
            scan_done <= 1'b0;
        end else begin
            step      <= step_nxt;
            scan_done <= done_nxt;
        end
    end
`else
    assign scan_done = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_scanner.sv
// Self-checking bench for decoder_scanner (N=3): vector table, hand sequences,
// then random stimulus against a queue-based reference model.
module tb_decoder_scanner;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       load = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] y;
    logic       busy;
    logic       scan_done;

`ifdef DECODER_SCAN_EN
    localparam bit SCAN_BUILD = 1'b1;
`else
    localparam bit SCAN_BUILD = 1'b0;
`endif

    decoder_scanner #(.N(3)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .mode(mode),
        .addr(addr), .y(y), .busy(busy), .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         en, ld, md;
        logic [2:0] ad;
        logic [7:0] ey;
        bit         eb, ed;
    } vec_t;
    vec_t vecs[$];

    // reference model: queue of indices still to show, front is the one on display
    int         q[$];
    bit         m_paused, m_scan;
    logic [7:0] m_y;
    bit         m_busy, m_done;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_show();
        if (q.size() > 0) begin
            m_y    = 8'h01 << q[0];
            m_done = m_scan && (q.size() == 1);
        end else begin
            m_y    = 8'h00;
            m_done = 1'b0;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_paused = 1'b0; m_scan = 1'b0;
        m_y = 8'h00; m_busy = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit ld, input bit md, input logic [2:0] ad);
        if (!en) begin
            m_y = 8'h00; m_done = 1'b0;
            m_paused = (q.size() > 0);
        end else if (m_paused) begin
            m_paused = 1'b0;
            model_show();
        end else if (q.size() > 0) begin
            void'(q.pop_front());
            model_show();
        end else if (ld) begin
            m_scan = md && SCAN_BUILD;
            if (m_scan) for (int i = 0; i < 8; i++) q.push_back((int'(ad) + i) % 8);
            else q.push_back(int'(ad));
            model_show();
        end else begin
            m_y = 8'h00; m_done = 1'b0;
        end
        m_busy = (q.size() > 0);
    endtask

    task automatic step(input bit en, input bit ld, input bit md, input logic [2:0] ad);
        @(negedge clk);
        enable = en; load = ld; mode = md; addr = ad;
        @(posedge clk);
        model_edge(en, ld, md, ad);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; enable = 1'b0; load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic expect3(input string nm, input logic [7:0] ey, input bit eb, input bit ed);
        check({nm, " y"}, 32'(y), 32'(ey));
        check({nm, " busy"}, 32'(busy), 32'(eb));
        check({nm, " scan_done"}, 32'(scan_done), 32'(ed));
    endtask

    initial begin
        // vector table
        for (int a = 0; a < 8; a++) begin
            vecs.push_back('{1, 1, 0, 3'(a), 8'h01 << a, 1, 0});
            vecs.push_back('{1, 0, 0, 3'd0, 8'h00, 0, 0});
        end
        if (SCAN_BUILD) begin
            logic [7:0] seq [8];
            seq = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
            vecs.push_back('{1, 1, 1, 3'd6, seq[0], 1, 0});
            for (int i = 1; i < 8; i++) vecs.push_back('{1, 0, 0, 3'd0, seq[i], 1, (i == 7)});
            vecs.push_back('{1, 0, 0, 3'd0, 8'h00, 0, 0});
        end else begin
            vecs.push_back('{1, 1, 1, 3'd5, 8'h20, 1, 0});
            vecs.push_back('{1, 0, 0, 3'd0, 8'h00, 0, 0});
        end

        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // asynchronous reset mid-cycle with output active
        step(1, 1, 0, 3'd4);
        check("pre-reset y", 32'(y), 32'h10);
        #2 rst_n = 1'b0;
        #1 expect3("async reset", 8'h00, 0, 0);
        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].ld, vecs[i].md, vecs[i].ad);
            expect3($sformatf("vec%0d", i), vecs[i].ey, vecs[i].eb, vecs[i].ed);
        end

        // pause inside DIRECT
        do_reset();
        step(1, 1, 0, 3'd2);  expect3("dpause load", 8'h04, 1, 0);
        step(0, 0, 0, 3'd0);  expect3("dpause off", 8'h00, 1, 0);
        step(1, 0, 0, 3'd0);  expect3("dpause resume", 8'h04, 1, 0);
        step(1, 0, 0, 3'd0);  expect3("dpause end", 8'h00, 0, 0);

        if (SCAN_BUILD) begin
            // enable pause during scan at y=0x02
            do_reset();
            step(1, 1, 1, 3'd0);  expect3("spause load", 8'h01, 1, 0);
            step(1, 0, 0, 3'd0);  expect3("spause at 02", 8'h02, 1, 0);
            for (int i = 0; i < 3; i++) begin
                step(0, 0, 0, 3'd0); expect3($sformatf("spause off%0d", i), 8'h00, 1, 0);
            end
            step(1, 0, 0, 3'd0);  expect3("spause resume", 8'h02, 1, 0);
            step(1, 0, 0, 3'd0);  expect3("spause next", 8'h04, 1, 0);
            for (int i = 0; i < 5; i++) step(1, 0, 0, 3'd0);
            expect3("spause last", 8'h80, 1, 1);
            step(1, 0, 0, 3'd0);  expect3("spause idle", 8'h00, 0, 0);

            // ignored load, then abort by reset at step 4
            do_reset();
            step(1, 1, 1, 3'd1);  expect3("abort s1", 8'h02, 1, 0);
            step(1, 1, 0, 3'd7);  expect3("ignored load", 8'h04, 1, 0);
            step(1, 0, 0, 3'd0);  expect3("abort s3", 8'h08, 1, 0);
            step(1, 0, 0, 3'd0);  expect3("abort s4", 8'h10, 1, 0);
            #2 rst_n = 1'b0;
            #1 expect3("abort async", 8'h00, 0, 0);
            @(posedge clk); #1 expect3("abort held", 8'h00, 0, 0);
            @(negedge clk);
            rst_n = 1'b1; enable = 1'b1; load = 1'b1; mode = 1'b0; addr = 3'd3;
            @(posedge clk); #1 expect3("first load", 8'h08, 1, 0);
            step(1, 0, 0, 3'd0);  expect3("after abort idle", 8'h00, 0, 0);
        end

        // random stimulus vs reference model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            check($sformatf("rnd%0d y", c), 32'(y), 32'(m_y));
            check($sformatf("rnd%0d busy", c), 32'(busy), 32'(m_busy));
            check($sformatf("rnd%0d scan_done", c), 32'(scan_done), 32'(m_done));
            check($sformatf("rnd%0d onehot0", c), 32'($onehot0(y)), 32'd1);
            if (c == 300) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decoder_scanner.md
DECODER_SCANNER -- requirements
Module: decoder_scanner

Interface
REQ-001 Parameter: N, default 3, address width; output width is 2**N (N=3 gives the 3-to-8 case).
REQ-002 Port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: enable  input  1  global enable; 0 forces y to zero on the next edge and freezes the FSM.
REQ-005 Port: load  input  1  command strobe, sampled only when the FSM is IDLE and enable=1.
REQ-006 Port: mode  input  1  command type: 0=direct decode, 1=scan; sampled with load.
REQ-007 Port: addr  input  N  decode index (direct mode) or start index (scan mode); sampled with load.
REQ-008 Port: y  output  2**N  registered one-hot output, or all-zero.
REQ-009 Port: busy  output  1  high while the FSM is not IDLE.
REQ-010 Port: scan_done  output  1  one-cycle pulse on the last scan step.

Function
REQ-011 The FSM SHALL have three states: IDLE, DIRECT and SCAN, with a registered N-bit index counter idx.
REQ-012 In IDLE with enable=1, load=1, mode=0: the FSM SHALL go to DIRECT, and y SHALL equal 1<<addr after the same edge (latency 1 cycle).
REQ-013 DIRECT SHALL hold y stable for exactly 1 cycle, then return to IDLE; y SHALL clear to 0 on that return edge.
REQ-014 In IDLE with enable=1, load=1, mode=1: the FSM SHALL go to SCAN with idx=addr, and y SHALL equal 1<<addr after that edge.
REQ-015 In SCAN, each enabled cycle SHALL advance idx by 1 modulo 2**N, wrapping from 2**N-1 to 0, with y=1<<idx.
REQ-016 A scan SHALL present exactly 2**N distinct one-hot values; scan_done SHALL be high during the cycle y shows the last one (index addr-1 mod 2**N), and the FSM SHALL then return to IDLE with y=0.
REQ-017 load while busy=1 SHALL be ignored, with no queuing.
REQ-018 enable=0 in any state SHALL drive y=0 and busy unchanged, with no state or idx advance; on re-enable, y SHALL resume 1<<idx and the scan SHALL continue where it stopped.
REQ-019 Exactly one bit or zero bits of y SHALL be high in every cycle.
REQ-020 busy SHALL be a registered decode of state and SHALL be high in DIRECT and SCAN.

Reset
REQ-021 rst_n low SHALL immediately, without a clock, force state=IDLE, idx=0, y=0, busy=0 and scan_done=0.
REQ-022 Reset asserted mid-scan SHALL abort the scan with no scan_done pulse; the first load after deassertion SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-023 Macro DECODER_SCAN_EN: when defined, SCAN mode is implemented as above.
REQ-024 Without DECODER_SCAN_EN, mode SHALL be ignored, so every load is treated as direct; scan_done SHALL be tied 0, and the SCAN state and wrap logic SHALL be absent.

Verification
REQ-025 Reset: rst_n=0 mid-cycle -> y=0, busy=0 and scan_done=0 immediately, before any clock edge.
REQ-026 Direct sweep, N=3: for addr=0..7, load, mode=0 -> next cycle y=8'h01<<addr and busy=1; the cycle after, y=0 and busy=0.
REQ-027 Scan wrap, N=3: addr=6, mode=1 -> y sequence 0x40, 0x80, 0x01, 0x02, 0x04, 0x08, 0x10, 0x20; scan_done high with 0x20; then y=0.
REQ-028 Enable pause: during a scan at y=0x02, enable=0 for 3 cycles -> y=0 and idx held; on re-enable, y=0x02 and the sequence continues.
REQ-029 Ignored load and abort: load during a scan -> no sequence change; rst_n=0 at step 4 -> no scan_done, then idle.
REQ-030 Build without DECODER_SCAN_EN: load with mode=1 and addr=5 -> y=0x20 for one cycle and scan_done stays 0.
